router_fsm: RTL and testbench

- Packet-level controller for the 1x3 router input path.
- Decodes the 2-bit destination in the header byte and sequences header, payload and parity loading through the register block into one of three output FIFOs.
- Handles FIFO-full stalls, waits for a busy destination FIFO to drain, and aborts on a destination soft reset.
- Drives the router_sync block (detect_add, write_enb_reg) and the register block (lfd/ld/laf/full states, rst_int_reg). Asserts busy to throttle the source.

---
 rtl/router_fsm.sv | 129 ++++++++++++
 tb/tb_router_fsm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// Packet-level controller for the 1x3 router input path: decodes the header
// destination and sequences header/payload/parity loading into one of three FIFOs.
module router_fsm (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        DA  = 3'd0,
        LFD = 3'd1,
        LD  = 3'd2,
        LP  = 3'd3,
        FFS = 3'd4,
        LAF = 3'd5,
        WTE = 3'd6,
        CPE = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic       sel_empty_s;
    logic       sel_soft_rst_s;
    logic       hdr_empty_s;

    // State and latched destination register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DA;
            addr_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Per-port status muxes: latched address for later states, header bits in DA
    always_comb begin
        sel_empty_s    = 1'b0;
        sel_soft_rst_s = 1'b0;
        hdr_empty_s    = 1'b0;
        case (addr_q)
            2'b00:   begin sel_empty_s = fifo_empty_0; sel_soft_rst_s = soft_reset_0; end
            2'b01:   begin sel_empty_s = fifo_empty_1; sel_soft_rst_s = soft_reset_1; end
            2'b10:   begin sel_empty_s = fifo_empty_2; sel_soft_rst_s = soft_reset_2; end
            default: begin sel_empty_s = 1'b0;         sel_soft_rst_s = 1'b0;         end
        endcase
        case (data_in)
            2'b00:   hdr_empty_s = fifo_empty_0;
            2'b01:   hdr_empty_s = fifo_empty_1;
            2'b10:   hdr_empty_s = fifo_empty_2;
            default: hdr_empty_s = 1'b0;
        endcase
    end

    // Next-state logic; an addressed soft reset aborts any packet in flight
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if ((state_q != DA) && sel_soft_rst_s) begin
            state_d = DA;
        end else begin
            case (state_q)
                DA: begin
                    if (pkt_valid && (data_in != 2'b11)) begin
                        addr_d  = data_in;
                        state_d = hdr_empty_s ? LFD : WTE;
                    end else begin
                        state_d = DA;
                    end
                end
                LFD: state_d = LD;
                LD: begin
                    if (fifo_full) begin
                        state_d = FFS;
                    end else if (!pkt_valid) begin
                        state_d = LP;
                    end else begin
                        state_d = LD;
                    end
                end
                FFS: state_d = fifo_full ? FFS : LAF;
                LAF: begin
                    if (parity_done) begin
                        state_d = DA;
                    end else if (low_pkt_valid) begin
                        state_d = LP;
                    end else begin
                        state_d = LD;
                    end
                end
                LP:  state_d = CPE;
                CPE: state_d = fifo_full ? FFS : DA;
                WTE: state_d = sel_empty_s ? LFD : WTE;
                default: state_d = DA;
            endcase
        end
    end

    assign detect_add    = (state_q == DA);
    assign lfd_state     = (state_q == LFD);
    assign ld_state      = (state_q == LD);
    assign laf_state     = (state_q == LAF);
    assign full_state    = (state_q == FFS);
    assign write_enb_reg = (state_q == LD) || (state_q == LP) || (state_q == LAF);
    assign rst_int_reg   = (state_q == CPE);
    assign busy          = !((state_q == DA) || (state_q == LD));
    assign state_out     = state_q;

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm: walks the packet scenarios
// and checks state plus every decoded output after each clock edge.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid, parity_done, low_pkt_valid, fifo_full;
    logic [1:0] data_in;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
    logic [2:0] state_out;

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt;
    int ri_cnt;

    router_fsm dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy), .state_out(state_out)
    );

    always #5 clock = ~clock;

    // Expected output vector {detect_add,lfd,ld,laf,full,we,rst_int,busy} per state
    function automatic logic [7:0] exp_outs(input logic [2:0] s);
        case (s)
            3'd0:    exp_outs = 8'b1000_0000;
            3'd1:    exp_outs = 8'b0100_0001;
            3'd2:    exp_outs = 8'b0010_0100;
            3'd3:    exp_outs = 8'b0000_0101;
            3'd4:    exp_outs = 8'b0000_1001;
            3'd5:    exp_outs = 8'b0001_0101;
            3'd6:    exp_outs = 8'b0000_0001;
            default: exp_outs = 8'b0000_0011;
        endcase
    endfunction

    task automatic chk_st(input string tag, input logic [2:0] exp_s);
        logic [7:0] obs_o;
        obs_o = {detect_add, lfd_state, ld_state, laf_state, full_state,
                 write_enb_reg, rst_int_reg, busy};
        n_checks++;
        assert (state_out === exp_s) else begin
            n_errors++;
            $error("FAIL %s state_out observed=%0d expected=%0d", tag, state_out, exp_s);
        end
        n_checks++;
        assert (obs_o === exp_outs(exp_s)) else begin
            n_errors++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs_o, exp_outs(exp_s));
        end
        if (write_enb_reg === 1'b1) we_cnt++;
        if (rst_int_reg === 1'b1) ri_cnt++;
    endtask

    task automatic chk_cnt(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'b00;
        parity_done = 1'b0; low_pkt_valid = 1'b0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        we_cnt = 0; ri_cnt = 0;
        #1;
        chk_st("reset", 3'd0);
        tick(); tick();
        chk_st("reset_hold", 3'd0);
        resetn = 1'b1;

        // Clean packet to port 1: 0,1,2,2,2,2,3,7,0
        data_in = 2'b01; pkt_valid = 1'b1;
        we_cnt = 0; ri_cnt = 0;
        chk_st("p1_da", 3'd0);
        tick(); chk_st("p1_lfd", 3'd1);
        data_in = 2'b11;
        tick(); chk_st("p1_ld1", 3'd2);
        tick(); chk_st("p1_ld2", 3'd2);
        tick(); chk_st("p1_ld3", 3'd2);
        tick(); chk_st("p1_ld4", 3'd2);
        pkt_valid = 1'b0;
        tick(); chk_st("p1_lp", 3'd3);
        tick(); chk_st("p1_cpe", 3'd7);
        tick(); chk_st("p1_da_end", 3'd0);
        chk_cnt("p1_we_cycles", we_cnt, 5);
        chk_cnt("p1_rst_int_cycles", ri_cnt, 1);

        // Busy destination port 2; other ports empty must not release WTE
        data_in = 2'b10; pkt_valid = 1'b1; fifo_empty_2 = 1'b0;
        tick(); chk_st("wte_1", 3'd6);
        data_in = 2'b00;
        for (int i = 2; i <= 5; i++) begin
            tick(); chk_st($sformatf("wte_%0d", i), 3'd6);
        end
        fifo_empty_2 = 1'b1;
        tick(); chk_st("wte_lfd", 3'd1);
        tick(); chk_st("wte_ld", 3'd2);

        // Full stall in LD: FFS x3, LAF, back to LD
        fifo_full = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick(); chk_st($sformatf("ffs_%0d", i), 3'd4);
        end
        fifo_full = 1'b0;
        tick(); chk_st("laf", 3'd5);
        tick(); chk_st("laf_ld", 3'd2);

        // Non-addressed soft reset ignored; addressed one (port 2) aborts
        soft_reset_1 = 1'b1; soft_reset_0 = 1'b1;
        tick(); chk_st("srst_other", 3'd2);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b0; soft_reset_2 = 1'b1;
        tick(); chk_st("srst_p2", 3'd0);
        soft_reset_2 = 1'b0; pkt_valid = 1'b0;

        // Full during parity check, then parity_done in LAF returns to DA
        data_in = 2'b00; pkt_valid = 1'b1;
        tick(); chk_st("fp_lfd", 3'd1);
        tick(); chk_st("fp_ld", 3'd2);
        pkt_valid = 1'b0;
        tick(); chk_st("fp_lp", 3'd3);
        fifo_full = 1'b1;
        tick(); chk_st("fp_cpe", 3'd7);
        tick(); chk_st("fp_ffs", 3'd4);
        fifo_full = 1'b0; parity_done = 1'b1;
        tick(); chk_st("fp_laf", 3'd5);
        tick(); chk_st("fp_da", 3'd0);
        parity_done = 1'b0;

        // LAF with low_pkt_valid goes to LP
        data_in = 2'b01; pkt_valid = 1'b1;
        tick(); chk_st("lo_lfd", 3'd1);
        fifo_full = 1'b1;
        tick(); chk_st("lo_ld", 3'd2);
        tick(); chk_st("lo_ffs", 3'd4);
        fifo_full = 1'b0; low_pkt_valid = 1'b1;
        tick(); chk_st("lo_laf", 3'd5);
        tick(); chk_st("lo_lp", 3'd3);
        low_pkt_valid = 1'b0; pkt_valid = 1'b0;
        tick(); chk_st("lo_cpe", 3'd7);
        tick(); chk_st("lo_da", 3'd0);

        // Soft-reset abort on port 0; soft_reset_1 has no effect
        data_in = 2'b00; pkt_valid = 1'b1;
        tick(); chk_st("sa_lfd", 3'd1);
        tick(); chk_st("sa_ld", 3'd2);
        soft_reset_1 = 1'b1;
        tick(); chk_st("sa_other", 3'd2);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        tick(); chk_st("sa_abort", 3'd0);
        pkt_valid = 1'b0;
        tick(); chk_st("sa_da_ignore", 3'd0);
        soft_reset_0 = 1'b0;

        // Invalid address ignored, then async reset mid-LD
        data_in = 2'b11; pkt_valid = 1'b1;
        tick(); chk_st("inv_da", 3'd0);
        tick(); chk_st("inv_da2", 3'd0);
        data_in = 2'b01;
        tick(); chk_st("ar_lfd", 3'd1);
        tick(); chk_st("ar_ld", 3'd2);
        #2;
        resetn = 1'b0;
        #1;
        chk_st("ar_async", 3'd0);
        tick(); chk_st("ar_hold", 3'd0);
        resetn = 1'b1; pkt_valid = 1'b0;
        tick(); chk_st("ar_restart", 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
